// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder family: mode encodings and PULSE FSM states.
package decoder_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational select-to-one-hot decoder with an unsigned in-range flag.
module onehot_dec #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] onehot,
    output logic               in_range
);

    logic [31:0] sel_ext;

    assign sel_ext  = 32'(sel);
    assign in_range = (sel_ext < 32'(NUM_OUT));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot[i] = in_range && (sel_ext == 32'(i));
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with DIRECT, SCAN and handshaked PULSE modes.
module onehot_decoder_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int NUM_OUT   = 8,
    parameter int DWELL     = 4,
    parameter int PULSE_LEN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out,
    output logic [SEL_W-1:0]   idx,
    output logic               err
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int PL_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [PL_W-1:0]  PULSE_LAST = PL_W'(PULSE_LEN - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(NUM_OUT - 1);

    logic [1:0]         mode_q;
    pulse_state_t       state;
    logic [DW_W-1:0]    dwell_q;
    logic [DW_W-1:0]    dwell_next;
    logic [PL_W-1:0]    pcnt_q;
    logic [SEL_W-1:0]   idx_next;
    logic [SEL_W-1:0]   dec_sel;
    logic [NUM_OUT-1:0] dec_onehot;
    logic               dec_in_range;
    logic               switching;

    assign switching = (mode != mode_q);

    // A dwell cycle is credited only when the index was actually shown, so a pause
    // (out forced to zero) keeps the remaining dwell for the resumed index.
    always_comb begin
        idx_next   = idx;
        dwell_next = dwell_q;
        if (out != '0) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_next = '0;
                idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                dwell_next = dwell_q + 1'b1;
            end
        end
    end

    assign dec_sel = (mode_q == MODE_SCAN) ? idx_next : sel;

    onehot_dec #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .sel      (dec_sel),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    always_comb begin
        in_ready = 1'b0;
        if (!rst && !switching) begin
            case (mode_q)
                MODE_DIRECT: in_ready = 1'b1;
                MODE_PULSE:  in_ready = en && (state == IDLE);
                default:     in_ready = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            idx     <= '0;
            err     <= 1'b0;
            mode_q  <= MODE_DIRECT;
            state   <= IDLE;
            dwell_q <= '0;
            pcnt_q  <= '0;
        end else begin
            err <= 1'b0;
            if (switching) begin
                out     <= '0;
                idx     <= '0;
                dwell_q <= '0;
                pcnt_q  <= '0;
                state   <= IDLE;
                mode_q  <= mode;
            end else begin
                case (mode_q)
                    MODE_DIRECT: begin
                        if (en) begin
                            out <= dec_onehot;
                            if (dec_in_range) idx <= sel;
                            else              err <= 1'b1;
                        end else begin
                            out <= '0;
                        end
                    end
                    MODE_SCAN: begin
                        idx     <= idx_next;
                        dwell_q <= dwell_next;
                        out     <= en ? dec_onehot : '0;
                    end
                    MODE_PULSE: begin
                        if (state == IDLE) begin
                            if (in_valid && in_ready) begin
                                if (dec_in_range) begin
                                    out    <= dec_onehot;
                                    idx    <= sel;
                                    pcnt_q <= '0;
                                    state  <= ACTIVE;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                        end else if (!en || pcnt_q == PULSE_LAST) begin
                            out   <= '0;
                            state <= IDLE;
                        end else begin
                            pcnt_q <= pcnt_q + 1'b1;
                        end
                    end
                    default: out <= '0;
                endcase
            end
        end
    end

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Parametrised, registered binary-to-one-hot decoder, the successor to the team's combinational 3-to-8 decoder. It has three operating modes:
- **DIRECT:** registered decode.
- **SCAN:** free-running one-hot row/LED scan with programmable dwell.
- **PULSE:** handshaked one-shot strobe of fixed length.

It sits between control logic and select lines (LED rows, keypad columns, chip selects) and flags out-of-range select values.

## Interface
- `SEL_W`, 3: select width.
- `NUM_OUT`, 8: number of one-hot outputs; 2 ≤ `NUM_OUT` ≤ 2**`SEL_W`.
- `DWELL`, 4: cycles each output is held in SCAN; ≥ 1.
- `PULSE_LEN`, 2: cycles an output is held in PULSE; ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `en`  in  1  global enable.
- `mode`  in  2  00 DIRECT, 01 SCAN, 10 PULSE, 11 reserved (OFF).
- `sel`  in  `SEL_W`  index to decode.
- `in_valid`  in  1  PULSE request.
- `in_ready`  out  1  request accepted when `in_valid` and `in_ready` are both high.
- `out`  out  `NUM_OUT`  one-hot or all-zero output.
- `idx`  out  `SEL_W`  index of the asserted bit; holds the last value when `out` = 0.
- `err`  out  1  one-cycle pulse on an out-of-range `sel`.

## Operation
- **Reset values:** `out`=0, `idx`=0, `err`=0, internal `mode_q`=DIRECT, PULSE state IDLE, dwell and pulse counters 0. `in_ready`=0 while `rst` is high.
- **Mode switch:** when `mode` ≠ `mode_q`, that cycle is a switch cycle.
  - Next edge: `out`<=0, `idx`<=0, counters cleared, state<=IDLE, `mode_q`<=`mode`.
  - The new mode acts from the following cycle.
  - `in_ready`=0 during a switch cycle.
- **DIRECT** (`in_valid` ignored, `in_ready`=1):
  - `en` high and `sel` < `NUM_OUT`: `out`<=1<<`sel`, `idx`<=`sel`.
  - `en` high and `sel` ≥ `NUM_OUT`: `out`<=0, `err`<=1.
  - `en` low: `out`<=0.
- **SCAN** (`in_ready`=0, `sel` ignored):
  - While `en` is high, `out` = 1<<`idx`.
  - The dwell counter counts 0..`DWELL`-1. At `DWELL`-1, `idx` advances, wrapping from `NUM_OUT`-1 to 0.
  - The first cycle after entry drives `idx` 0 with a fresh dwell.
  - `en` low: `out`<=0; `idx` and the dwell counter freeze. Resume continues the same index and remaining dwell.
- **PULSE**, FSM IDLE/ACTIVE:
  - IDLE: `in_ready`=`en`.
  - Accept with `sel` < `NUM_OUT`: `out`<=1<<`sel`, `idx`<=`sel`, count<=0, go ACTIVE.
  - Accept with `sel` ≥ `NUM_OUT`: `err`<=1, stay IDLE, `out` stays 0.
  - ACTIVE: `in_ready`=0; count increments. At count `PULSE_LEN`-1: `out`<=0, go IDLE.
  - `en` low in ACTIVE: abort; `out`<=0, go IDLE next edge.
  - `in_valid` while ACTIVE is not accepted and not queued.
- **OFF** (mode 11): `out`=0, `in_ready`=0, `err`=0.
- **Range rule:** `sel` is compared as unsigned against `NUM_OUT`. When `NUM_OUT`=2**`SEL_W`, `err` never fires.

## Timing
- `out`, `idx` and `err` are registered. `in_ready` is combinational from `mode`, `mode_q`, state, `en` and `rst`.
- **DIRECT latency:** 1 cycle from `sel` to `out`.
- **PULSE:**
  - `out` rises on the edge after acceptance and stays high exactly `PULSE_LEN` cycles.
  - `in_ready` returns to 1 in the cycle after `out` falls.
  - Back-to-back period is `PULSE_LEN`+1 cycles.
- **SCAN:** period = `NUM_OUT`×`DWELL` cycles. Exactly one bit is high in every enabled cycle, with no gap cycles between indices.
- **`err`:** high for exactly one cycle, the cycle after the offending sample or acceptance.
- **Asynchronous `rst` mid-operation:** all outputs go to reset values immediately. Operation restarts in DIRECT on the first edge after `rst` falls.

## Structure
- Package `decoder_pkg` holds:
  - mode encodings `MODE_DIRECT`, `MODE_SCAN`, `MODE_PULSE`, `MODE_OFF`;
  - PULSE state typedef `pulse_state_t` (IDLE, ACTIVE).
- Sub-module `onehot_dec`: combinational `sel` → one-hot of `NUM_OUT` bits plus an in-range flag. It is shared by DIRECT, PULSE and SCAN (which decodes `idx`).
- Dwell and pulse counters are sized $clog2 of the parameter and live in the top level.

## Test plan
- **Reset:** assert `rst` mid-SCAN → `out`=0, `idx`=0, `err`=0 and `in_ready`=0 immediately; after release, DIRECT `sel`=5 → `out`=8'h20 one cycle later.
- **DIRECT range check** (`NUM_OUT`=6, `SEL_W`=3):
  - `sel`=3 → `out`=6'b001000.
  - `sel`=7 → `out`=0 and a single-cycle `err` pulse.
- **SCAN** (defaults): `out` steps 0x01, 0x02, …, 0x80 every 4 cycles, then wraps to 0x01 at cycle 32.
  - `en` low for 3 cycles mid-dwell → `out`=0; on resume, the same index finishes its remaining dwell.
- **PULSE** (`PULSE_LEN`=2):
  - Accept `sel`=2 → `out`=0x04 for exactly 2 cycles; `in_ready`=0 for those 2 cycles and returns to 1 one cycle after `out` falls.
  - Held `in_valid` → second pulse starts 3 cycles after the first.
- **PULSE abort:** drop `en` in the first ACTIVE cycle → `out`=0 next edge, state IDLE, no `err`.
- **Mode switch:** switch from SCAN (at `idx`=5) to DIRECT with `sel`=1 → one cycle of `out`=0 and `idx`=0, then `out`=0x02.
